// File: rtl/sprite_fetch_ctrl.sv
// Sprite fetch controller.
// Load side: streams colour nibbles from a loader into sprite RAM during
// video blanking, in raster order, SPRITE_W*SPRITE_H entries per sprite.
// Read side: every cycle, maps the current draw pixel onto a sprite RAM
// address. One cycle later the RAM returns the colour. The hit flag is
// delayed to line up with that colour, and transparent entries are masked.
//
// Loader handshake: ld_data is accepted on any rising edge where
// ld_valid and ld_ready are both 1. The loader holds ld_valid and ld_data
// steady until that edge. ld_ready is never raised outside blanking.
module sprite_fetch_ctrl #(
    parameter int         SPRITE_W = 30,
    parameter int         SPRITE_H = 30,
    parameter logic [3:0] TRANSP   = 4'h0
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        blank,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  SpriteX,
    input  logic [9:0]  SpriteY,
    input  logic        ld_valid,
    input  logic [3:0]  ld_data,
    output logic        ld_ready,
    output logic        load_done,
    output logic        ram_we,
    output logic [18:0] ram_write_address,
    output logic [3:0]  ram_data_In,
    output logic [18:0] ram_read_address,
    input  logic [3:0]  ram_data_Out,
    output logic        pix_valid,
    output logic [3:0]  pix_color,
    output logic [1:0]  dbg_state
);

    localparam int          NPIX      = SPRITE_W * SPRITE_H;
    localparam logic [18:0] LAST_ADDR = 19'(NPIX - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } load_state_t;

    load_state_t state, state_nxt;
    logic [18:0] wr_ptr, wr_ptr_nxt;
    logic        load_done_nxt;
    logic        xfer;

    // Load FSM state, write pointer and the registered completion pulse.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            load_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            wr_ptr    <= wr_ptr_nxt;
            load_done <= load_done_nxt;
        end
    end

    // Load FSM next state, handshake and write-port control.
    always_comb begin
        state_nxt     = state;
        wr_ptr_nxt    = wr_ptr;
        load_done_nxt = 1'b0;
        ld_ready      = 1'b0;
        xfer          = 1'b0;
        case (state)
            IDLE: begin
                wr_ptr_nxt = '0;
                if (blank && ld_valid) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                ld_ready = blank;
                xfer     = ld_valid && blank;
                if (xfer) begin
                    if (wr_ptr == LAST_ADDR) begin
                        wr_ptr_nxt    = '0;
                        load_done_nxt = 1'b1;
                        state_nxt     = IDLE;
                    end else begin
                        wr_ptr_nxt = wr_ptr + 19'd1;
                    end
                end else if (!blank && (wr_ptr != '0)) begin
                    // Active video interrupted a partial load: park and keep progress.
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (blank) begin
                    state_nxt = LOAD;
                end
            end
            default: begin
                state_nxt  = IDLE;
                wr_ptr_nxt = '0;
            end
        endcase
    end

    assign ram_we            = xfer;
    assign ram_write_address = wr_ptr;
    assign ram_data_In       = ld_data;
    assign dbg_state         = state;

    // Bounding-box test in 11 bits so SpriteX+SPRITE_W never wraps.
    logic [10:0] dx, dy, sx, sy, sx_end, sy_end;
    logic        hit;
    logic [9:0]  rel_x, rel_y;
    logic [18:0] rd_addr_nxt;

    assign dx          = {1'b0, DrawX};
    assign dy          = {1'b0, DrawY};
    assign sx          = {1'b0, SpriteX};
    assign sy          = {1'b0, SpriteY};
    assign sx_end      = sx + 11'(SPRITE_W);
    assign sy_end      = sy + 11'(SPRITE_H);
    assign hit         = (dx >= sx) && (dx < sx_end) && (dy >= sy) && (dy < sy_end);
    assign rel_x       = DrawX - SpriteX;
    assign rel_y       = DrawY - SpriteY;
    assign rd_addr_nxt = 19'(rel_y) * 19'(SPRITE_W) + 19'(rel_x);

    logic hit_d1, hit_d2;

    // Read address register (held on miss) and hit pipeline aligned to RAM latency.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ram_read_address <= '0;
            hit_d1           <= 1'b0;
            hit_d2           <= 1'b0;
        end else begin
            if (hit) begin
                ram_read_address <= rd_addr_nxt;
            end
            hit_d1 <= hit;
            hit_d2 <= hit_d1;
        end
    end

    assign pix_valid = hit_d2 && (ram_data_Out != TRANSP);
    assign pix_color = pix_valid ? ram_data_Out : 4'h0;

endmodule
